// File: rtl/minmax_tracker_4_bits_pkg.sv
// Shared types and constants for the min/max tracker: data width, FSM state
// encoding and the comparator flag decode.
package minmax_tracker_4_bits_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    S_EMPTY  = 3'd0,
    S_ACCEPT = 3'd1,
    S_CMPMAX = 3'd2,
    S_CMPMIN = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  // EQUAL dominates HIGHER, so an equal pair never reads as greater or less.
  function automatic logic a_gt_b(input logic equal, input logic higher);
    return higher & ~equal;
  endfunction

  function automatic logic a_lt_b(input logic equal, input logic higher);
    return ~higher & ~equal;
  endfunction

endpackage

// File: rtl/minmax_tracker_4_bits_if.sv
// Bus bundle for minmax_tracker_4_bits: sample input, comparator link and frame
// result. OUT_MAX_IDX exists only when MINMAX_INDEX_EN is defined.
interface minmax_tracker_4_bits_if
  import minmax_tracker_4_bits_pkg::*;
#(
  parameter int CNT_W = 8
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are
  // both high; VALID and its payload stay stable until that edge, READY may
  // change freely and never depends on VALID.
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_LAST;
  logic [DATA_W-1:0] CMP_A;
  logic [DATA_W-1:0] CMP_B;
  logic              CMP_EQUAL;
  logic              CMP_HIGHER;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_MAX;
  logic [DATA_W-1:0] OUT_MIN;
  logic [CNT_W-1:0]  OUT_COUNT;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0]  OUT_MAX_IDX;
`endif

  modport master (
    output IN_VALID, IN_DATA, IN_LAST, CMP_EQUAL, CMP_HIGHER, OUT_READY,
`ifdef MINMAX_INDEX_EN
    input  OUT_MAX_IDX,
`endif
    input  IN_READY, CMP_A, CMP_B, OUT_VALID, OUT_MAX, OUT_MIN, OUT_COUNT
  );

  modport slave (
    input  IN_VALID, IN_DATA, IN_LAST, CMP_EQUAL, CMP_HIGHER, OUT_READY,
`ifdef MINMAX_INDEX_EN
    output OUT_MAX_IDX,
`endif
    output IN_READY, CMP_A, CMP_B, OUT_VALID, OUT_MAX, OUT_MIN, OUT_COUNT
  );

endinterface

// File: rtl/minmax_tracker_4_bits_fsm.sv
// Control FSM of the min/max tracker: state register plus next-state,
// IN_READY and OUT_VALID decode.
module minmax_tracker_4_bits_fsm
  import minmax_tracker_4_bits_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  logic   in_last,
  input  logic   last_q,
  input  logic   out_ready,
  output logic   in_ready,
  output logic   out_valid,
  output state_t state
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_last ? S_OUT : S_ACCEPT;
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_CMPMAX;
      end
      S_CMPMAX: state_d = S_CMPMIN;
      S_CMPMIN: state_d = last_q ? S_OUT : S_ACCEPT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/minmax_tracker_4_bits.sv
// Frame min/max tracker driven by an external 4-bit comparator's EQUAL/HIGHER
// flags. Optional MINMAX_INDEX_EN adds OUT_MAX_IDX (index of first maximum).
module minmax_tracker_4_bits
  import minmax_tracker_4_bits_pkg::*;
#(
  parameter int CNT_W = 8
)(
  input  logic                   CLK,
  input  logic                   RST,
  minmax_tracker_4_bits_if.slave bus,
  output state_t                 dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic              accept;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              last_q,   last_d;
  logic [DATA_W-1:0] max_q,    max_d;
  logic [DATA_W-1:0] min_q,    min_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] cmp_a_q,  cmp_a_d;
  logic [DATA_W-1:0] cmp_b_q,  cmp_b_d;
`ifdef MINMAX_INDEX_EN
  logic [CNT_W-1:0]  idx_q,    idx_d;
`endif

  minmax_tracker_4_bits_fsm u_fsm (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (bus.IN_VALID),
    .in_last   (bus.IN_LAST),
    .last_q    (last_q),
    .out_ready (bus.OUT_READY),
    .in_ready  (bus.IN_READY),
    .out_valid (bus.OUT_VALID),
    .state     (state)
  );

  assign accept = bus.IN_VALID & bus.IN_READY;

  // Comparator operands are loaded one state early so the flags seen in
  // S_CMPMAX/S_CMPMIN already reflect the registered operands.
  always_comb begin
    sample_d = sample_q;
    last_d   = last_q;
    max_d    = max_q;
    min_d    = min_q;
    count_d  = count_q;
    cmp_a_d  = cmp_a_q;
    cmp_b_d  = cmp_b_q;
`ifdef MINMAX_INDEX_EN
    idx_d    = idx_q;
`endif
    case (state)
      S_EMPTY: if (accept) begin
        max_d   = bus.IN_DATA;
        min_d   = bus.IN_DATA;
        count_d = CNT_ONE;
`ifdef MINMAX_INDEX_EN
        idx_d   = '0;
`endif
      end
      S_ACCEPT: if (accept) begin
        sample_d = bus.IN_DATA;
        last_d   = bus.IN_LAST;
        count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
        cmp_a_d  = bus.IN_DATA;
        cmp_b_d  = max_q;
      end
      S_CMPMAX: begin
        cmp_b_d = min_q;
        if (a_gt_b(bus.CMP_EQUAL, bus.CMP_HIGHER)) begin
          max_d = sample_q;
`ifdef MINMAX_INDEX_EN
          idx_d = count_q - CNT_ONE;
`endif
        end
      end
      S_CMPMIN: if (a_lt_b(bus.CMP_EQUAL, bus.CMP_HIGHER)) min_d = sample_q;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_q <= '0;
      last_q   <= 1'b0;
      max_q    <= '0;
      min_q    <= '0;
      count_q  <= '0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
    end else begin
      sample_q <= sample_d;
      last_q   <= last_d;
      max_q    <= max_d;
      min_q    <= min_d;
      count_q  <= count_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
    end
  end

`ifdef MINMAX_INDEX_EN
  always_ff @(posedge CLK) begin
    if (RST) idx_q <= '0;
    else     idx_q <= idx_d;
  end
  assign bus.OUT_MAX_IDX = idx_q;
`endif

  assign bus.CMP_A     = cmp_a_q;
  assign bus.CMP_B     = cmp_b_q;
  assign bus.OUT_MAX   = max_q;
  assign bus.OUT_MIN   = min_q;
  assign bus.OUT_COUNT = count_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_minmax_tracker_4_bits.sv
// Self-checking bench for minmax_tracker_4_bits: a CNT_W=8 and a CNT_W=2 instance,
// each with a behavioural comparator; expected frame results go through a queue.
module tb_minmax_tracker_4_bits;
  import minmax_tracker_4_bits_pkg::*;

  localparam int W = 24;  // {idx[7:0], max[3:0], min[3:0], count[7:0]}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minmax_tracker_4_bits_if #(.CNT_W(8)) bus8 ();
  minmax_tracker_4_bits_if #(.CNT_W(2)) bus2 ();
  state_t dbg8, dbg2;

  assign bus8.CMP_EQUAL  = (bus8.CMP_A == bus8.CMP_B);
  assign bus8.CMP_HIGHER = (bus8.CMP_A >  bus8.CMP_B);
  assign bus2.CMP_EQUAL  = (bus2.CMP_A == bus2.CMP_B);
  assign bus2.CMP_HIGHER = (bus2.CMP_A >  bus2.CMP_B);

  minmax_tracker_4_bits #(.CNT_W(8)) dut8 (.CLK(clk), .RST(rst), .bus(bus8.slave), .dbg_state(dbg8));
  minmax_tracker_4_bits #(.CNT_W(2)) dut2 (.CLK(clk), .RST(rst), .bus(bus2.slave), .dbg_state(dbg2));

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] obs_word(input int sel);
    logic [7:0] idx;
    idx = '0;
`ifdef MINMAX_INDEX_EN
    idx = (sel != 0) ? {6'd0, bus2.OUT_MAX_IDX} : bus8.OUT_MAX_IDX;
`endif
    if (sel != 0) return {idx, bus2.OUT_MAX, bus2.OUT_MIN, 6'd0, bus2.OUT_COUNT};
    return {idx, bus8.OUT_MAX, bus8.OUT_MIN, bus8.OUT_COUNT};
  endfunction

  // Reference: running max/min, saturating count, index of first strict maximum.
  function automatic logic [W-1:0] model(input logic [3:0] d[$], input int sat);
    logic [3:0] mx, mn;
    int cnt, idx;
    mx = d[0]; mn = d[0]; cnt = 1; idx = 0;
    for (int i = 1; i < d.size(); i++) begin
      if (cnt < sat) cnt++;
      if (d[i] > mx) begin mx = d[i]; idx = cnt - 1; end
      if (d[i] < mn) mn = d[i];
    end
`ifndef MINMAX_INDEX_EN
    idx = 0;
`endif
    return {idx[7:0], mx, mn, cnt[7:0]};
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [3:0] d, input logic l);
    if (sel != 0) begin bus2.IN_VALID = v; bus2.IN_DATA = d; bus2.IN_LAST = l; end
    else          begin bus8.IN_VALID = v; bus8.IN_DATA = d; bus8.IN_LAST = l; end
  endtask

  task automatic put_sample(input int sel, input logic [3:0] d, input logic l);
    int w = 0;
    @(negedge clk);
    drive_in(sel, 1'b1, d, l);
    while (!((sel != 0) ? bus2.IN_READY : bus8.IN_READY) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check_eq("in_ready_timeout", (sel != 0) ? bus2.IN_READY : bus8.IN_READY, 1);
    @(posedge clk);
    #1 drive_in(sel, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic send_frame(input int sel, input logic [3:0] d[$], input int sat);
    exp_q.push_back(model(d, sat));
    for (int i = 0; i < d.size(); i++) put_sample(sel, d[i], i == d.size() - 1);
  endtask

  task automatic get_result(input int sel, input int exp_lat, input int hold);
    int lat = 0;
    logic [W-1:0] exp;
    do begin
      @(negedge clk);
      lat++;
    end while (!((sel != 0) ? bus2.OUT_VALID : bus8.OUT_VALID) && lat < 20);
    check_eq("out_latency", lat, exp_lat);
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", exp_q.size(), 1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check_eq("result", obs_word(sel), exp);
    check_eq("in_ready_in_out", (sel != 0) ? bus2.IN_READY : bus8.IN_READY, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", (sel != 0) ? bus2.OUT_VALID : bus8.OUT_VALID, 1);
      check_eq("hold_in_ready", (sel != 0) ? bus2.IN_READY : bus8.IN_READY, 0);
      check_eq("hold_result", obs_word(sel), exp);
    end
    if (sel != 0) bus2.OUT_READY = 1'b1; else bus8.OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    bus2.OUT_READY = 1'b0;
    bus8.OUT_READY = 1'b0;
    @(negedge clk);
    check_eq("valid_drop", (sel != 0) ? bus2.OUT_VALID : bus8.OUT_VALID, 0);
    check_eq("ready_back", (sel != 0) ? bus2.IN_READY : bus8.IN_READY, 1);
    check_eq("result_held", obs_word(sel), exp);
  endtask

  task automatic check_idle8(input string tag);
    check_eq({tag, "_in_ready"}, bus8.IN_READY, 1);
    check_eq({tag, "_out_valid"}, bus8.OUT_VALID, 0);
    check_eq({tag, "_out_max"}, bus8.OUT_MAX, 0);
    check_eq({tag, "_out_min"}, bus8.OUT_MIN, 0);
    check_eq({tag, "_out_count"}, bus8.OUT_COUNT, 0);
    check_eq({tag, "_cmp_a"}, bus8.CMP_A, 0);
    check_eq({tag, "_cmp_b"}, bus8.CMP_B, 0);
`ifdef MINMAX_INDEX_EN
    check_eq({tag, "_max_idx"}, bus8.OUT_MAX_IDX, 0);
`endif
  endtask

  initial begin
    logic [3:0] frm[$];
    int len;
    rst = 1'b1;
    drive_in(0, 1'b0, 4'd0, 1'b0);
    drive_in(1, 1'b0, 4'd0, 1'b0);
    bus8.OUT_READY = 1'b0;
    bus2.OUT_READY = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle8("reset");
    check_eq("reset_count2", bus2.OUT_COUNT, 0);

    frm = '{4'd5, 4'd2, 4'd9, 4'd9, 4'd1};
    send_frame(0, frm, 255);
    get_result(0, 3, 0);

    frm = '{4'd7};
    send_frame(0, frm, 255);
    get_result(0, 1, 0);

    frm = '{4'd3, 4'd12, 4'd6};
    send_frame(0, frm, 255);
    get_result(0, 3, 10);

    // Reset lands while the frame 3,15 sits in S_CMPMAX; nothing is expected from it.
    put_sample(0, 4'd3, 1'b0);
    put_sample(0, 4'd15, 1'b0);
    check_eq("abort_state", dbg8, S_CMPMAX);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle8("abort_reset");
    frm = '{4'd4};
    send_frame(0, frm, 255);
    get_result(0, 1, 0);

    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 8);
      frm = {};
      for (int i = 0; i < len; i++)
        frm.push_back((f % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(6, 8)));
      send_frame(0, frm, 255);
      get_result(0, (len == 1) ? 1 : 3, $urandom_range(0, 2));
    end

    frm = '{4'd1, 4'd8, 4'd8};
    send_frame(0, frm, 255);
    get_result(0, 3, 0);

    frm = '{4'd2, 4'd9, 4'd4, 4'd9, 4'd15, 4'd0};
    send_frame(1, frm, 3);
    get_result(1, 3, 0);
    frm = '{4'd6, 4'd6};
    send_frame(1, frm, 3);
    get_result(1, 3, 0);

    frm = {};
    for (int i = 0; i < 260; i++) frm.push_back(4'($urandom_range(1, 14)));
    send_frame(0, frm, 255);
    get_result(0, 3, 0);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
